// File: rtl/tc0260dar.sv
// -----------------------------------------------------------------------------
// tc0260dar - palette DAC: 4096 x 16 palette RAM with a CPU read/write port and
// a two-stage video lookup producing 8-bit R/G/B from a 12-bit colour index.
//
// Ports
//   clk, resetn         : system clock, asynchronous active-low reset
//   ce_13m, ce_pixel    : clock enables; pixel tick = ce_13m & ce_pixel
//   VA[12:1], Din, LDSn, UDSn, RW, DARCSn : CPU bus (DARCSn falling edge starts
//                         a cycle); Dout read data, DACKn acknowledge
//   IM[11:0], HBLOn, VBLOn : colour index and active-low blanks
//   R, G, B, BLANKn     : video output, BLANKn low while blanked
//
// Build option
//   TC0260DAR_READBACK_EN : when defined, CPU reads return palette data;
//                           otherwise reads return 16'hFFFF and the RAM is
//                           write-only from the CPU side.
// -----------------------------------------------------------------------------
module tc0260dar (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ce_13m,
  input  logic        ce_pixel,
  input  logic [12:1] VA,
  input  logic [15:0] Din,
  input  logic        LDSn,
  input  logic        UDSn,
  input  logic        RW,
  input  logic        DARCSn,
  output logic [15:0] Dout,
  output logic        DACKn,
  input  logic [11:0] IM,
  input  logic        HBLOn,
  input  logic        VBLOn,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        BLANKn
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  // Palette storage; deliberately not cleared by reset.
  logic [15:0] pal_mem [4096];

  state_t      state_q, state_d;
  logic        cs_prev_q, cs_prev_d;
  logic [15:0] dout_q, dout_d;
  logic        we_hi, we_lo;

  logic [11:0] addr_q;
  logic        blank_d1_q;
  logic        blankn_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        pix_tick;

  function automatic logic [7:0] exp5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  assign pix_tick = ce_13m & ce_pixel;

  // ---------------------------------------------------------------------------
  // Video pipeline: stage 1 latches index and blank, stage 2 looks up and
  // expands. The RAM read sees the pre-write contents when the CPU writes the
  // same entry in the same clock.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      blank_d1_q <= 1'b1;
      blankn_q   <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else if (pix_tick) begin
      addr_q     <= IM;
      blank_d1_q <= ~(HBLOn & VBLOn);
      blankn_q   <= ~blank_d1_q;
      if (blank_d1_q) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else begin
        r_q <= exp5(pal_mem[addr_q][14:10]);
        g_q <= exp5(pal_mem[addr_q][9:5]);
        b_q <= exp5(pal_mem[addr_q][4:0]);
      end
    end
  end

  assign R      = r_q;
  assign G      = g_q;
  assign B      = b_q;
  assign BLANKn = blankn_q;

  // ---------------------------------------------------------------------------
  // CPU handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cs_prev_d = cs_prev_q;
    dout_d    = dout_q;
    we_hi     = 1'b0;
    we_lo     = 1'b0;
    if (ce_13m) begin
      cs_prev_d = DARCSn;
      case (state_q)
        S_IDLE: begin
          if (!DARCSn && cs_prev_q) state_d = S_ACCESS;
        end
        S_ACCESS: begin
          if (!RW) begin
            we_hi = ~UDSn;
            we_lo = ~LDSn;
          end else begin
`ifdef TC0260DAR_READBACK_EN
            dout_d = pal_mem[VA];
`else
            dout_d = 16'hFFFF;
`endif
          end
          // A strobe already released skips ACK, so no DACKn pulse appears.
          state_d = DARCSn ? S_IDLE : S_ACK;
        end
        S_ACK: begin
          if (DARCSn) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cs_prev_q <= 1'b1;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= cs_prev_d;
      dout_q    <= dout_d;
    end
  end

  // Write enables derive from state_q, which reset forces to IDLE, so a reset
  // during ACCESS discards the pending write.
  always_ff @(posedge clk) begin
    if (we_hi) pal_mem[VA][15:8] <= Din[15:8];
    if (we_lo) pal_mem[VA][7:0]  <= Din[7:0];
  end

  assign Dout  = dout_q;
  assign DACKn = ~((state_q == S_ACK) && !DARCSn);

endmodule

// File: tb/tb_tc0260dar.sv
// -----------------------------------------------------------------------------
// tb_tc0260dar - randomized self-checking bench for tc0260dar. A palette array
// and a queue of sampled pixels form the reference; expected video is taken
// from the pixel sampled one tick before the current one.
// -----------------------------------------------------------------------------
module tb_tc0260dar;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ce_13m, ce_pixel;
  logic [12:1] VA;
  logic [15:0] Din;
  logic        LDSn, UDSn, RW, DARCSn;
  logic [15:0] Dout;
  logic        DACKn;
  logic [11:0] IM;
  logic        HBLOn, VBLOn;
  logic [7:0]  R, G, B;
  logic        BLANKn;

  tc0260dar dut (
    .clk     (clk),
    .resetn  (resetn),
    .ce_13m  (ce_13m),
    .ce_pixel(ce_pixel),
    .VA      (VA),
    .Din     (Din),
    .LDSn    (LDSn),
    .UDSn    (UDSn),
    .RW      (RW),
    .DARCSn  (DARCSn),
    .Dout    (Dout),
    .DACKn   (DACKn),
    .IM      (IM),
    .HBLOn   (HBLOn),
    .VBLOn   (VBLOn),
    .R       (R),
    .G       (G),
    .B       (B),
    .BLANKn  (BLANKn)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] model_mem [4096];
  logic [12:0] hist [$];          // {blank, index} per pixel tick
  logic [24:0] exp_vid = '0;      // {BLANKn, R, G, B}
  logic [11:0] vaddr [16];
  logic [15:0] tmp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] colour(input logic [15:0] w);
    int unsigned r, g, b;
    r = (w >> 10) % 32;
    g = (w >> 5) % 32;
    b = w % 32;
    r = r * 8 + r / 4;
    g = g * 8 + g / 4;
    b = b * 8 + b / 4;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic logic [15:0] rd_expect(input logic [11:0] a);
`ifdef TC0260DAR_READBACK_EN
    return model_mem[a];
`else
    return 16'hFFFF;
`endif
  endfunction

  task automatic model_update;
    logic [12:0] p;
    if (hist.size() < 2) exp_vid = '0;
    else begin
      p = hist[hist.size()-2];
      exp_vid = p[12] ? 25'd0 : {1'b1, colour(model_mem[p[11:0]])};
    end
  endtask

  task automatic vid_reset_model;
    hist.delete();
    exp_vid = '0;
  endtask

  task automatic vid_cycle(input logic ce, input logic pix, input logic [11:0] im,
                           input logic hb, input logic vb);
    @(negedge clk);
    ce_13m = ce; ce_pixel = pix; IM = im; HBLOn = hb; VBLOn = vb;
    @(posedge clk);
    #1;
    if (ce && pix) begin
      hist.push_back({~(hb & vb), im});
      model_update();
    end
    chk("video", {BLANKn, R, G, B}, exp_vid);
  endtask

  task automatic cpu_xfer(input logic rw, input logic [11:0] a, input logic [15:0] d,
                          input logic u, input logic l, input int hold, input bit rnd);
    int lat, guard;
    @(negedge clk);
    ce_pixel = 1'b0; VA = a; Din = d; RW = rw; UDSn = u; LDSn = l; DARCSn = 1'b0;
    lat = 0; guard = 0;
    while (DACKn && guard < 200) begin
      ce_13m = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      if (ce_13m) lat++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) chk("ack_timeout", {31'd0, DACKn}, 32'd0);
    chk("ack_latency", lat, 2);
    if (rw) chk("rd_data", Dout, rd_expect(a));
    else begin
      if (!u) model_mem[a][15:8] = d[15:8];
      if (!l) model_mem[a][7:0]  = d[7:0];
    end
    // Changing Din while held would expose any repeated write.
    for (int i = 0; i < hold; i++) begin
      ce_13m = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      Din = ~d;
      @(posedge clk);
      #1;
      chk("ack_hold", {31'd0, DACKn}, 32'd0);
      @(negedge clk);
    end
    DARCSn = 1'b1; Din = d;
    #1;
    chk("ack_release", {31'd0, DACKn}, 32'd1);
    ce_13m = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    resetn = 1'b0; ce_13m = 1'b0; ce_pixel = 1'b0;
    VA = '0; Din = '0; LDSn = 1'b1; UDSn = 1'b1; RW = 1'b1; DARCSn = 1'b1;
    IM = '0; HBLOn = 1'b1; VBLOn = 1'b1;
    for (int unsigned i = 0; i < 16; i++) vaddr[i] = 12'h200 + 12'(i * 65);
    vaddr[0] = 12'h010; vaddr[1] = 12'hFFF; vaddr[2] = 12'h000; vaddr[3] = 12'h123;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", Dout, 0);
    chk("rst_dackn", {31'd0, DACKn}, 1);
    chk("rst_video", {BLANKn, R, G, B}, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Populate the probed entries.
    for (int unsigned i = 0; i < 16; i++) begin
      tmp = 16'($urandom);
      if (i == 0) tmp = 16'h7C00;
      if (i == 1) tmp = 16'h7FFF;
      cpu_xfer(1'b0, vaddr[i], tmp, 1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b1);
    end
    for (int unsigned i = 0; i < 6; i++)
      cpu_xfer(1'b1, vaddr[i], 16'h0, 1'b1, 1'b1, 1, 1'b1);

    // Low-byte-only write onto a zeroed entry.
    cpu_xfer(1'b0, 12'h055, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    cpu_xfer(1'b0, 12'h055, 16'h03E0, 1'b1, 1'b0, 0, 1'b0);
    cpu_xfer(1'b1, 12'h055, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
`ifdef TC0260DAR_READBACK_EN
    chk("lds_only_read", Dout, 16'h00E0);
`else
    chk("lds_only_read", Dout, 16'hFFFF);
`endif

    // Long strobe: ten ce cycles low, single write despite Din changing.
    cpu_xfer(1'b0, vaddr[7], 16'h1234, 1'b0, 1'b0, 8, 1'b0);
    // No byte strobes: handshake completes, entry untouched.
    cpu_xfer(1'b0, vaddr[6], ~model_mem[vaddr[6]], 1'b1, 1'b1, 1, 1'b1);

    // First RGB two ticks after reset, pure red from 7C00.
    vid_cycle(1'b1, 1'b1, 12'h010, 1'b1, 1'b1);
    chk("first_tick_blank", {BLANKn, R, G, B}, 0);
    vid_cycle(1'b1, 1'b1, 12'h010, 1'b1, 1'b1);
    chk("red_full", {BLANKn, R, G, B}, {1'b1, 24'hFF0000});
    vid_cycle(1'b1, 1'b1, vaddr[6], 1'b1, 1'b1);
    vid_cycle(1'b1, 1'b1, vaddr[7], 1'b1, 1'b1);
    vid_cycle(1'b1, 1'b1, vaddr[7], 1'b1, 1'b1);

    // Blank on white entry: two-tick latency both ways.
    vid_cycle(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1);
    vid_cycle(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1);
    chk("white", {BLANKn, R, G, B}, {1'b1, 24'hFFFFFF});
    vid_cycle(1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1);
    chk("blank_assert_t1", {BLANKn, R, G, B}, {1'b1, 24'hFFFFFF});
    vid_cycle(1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1);
    chk("blank_assert_t2", {BLANKn, R, G, B}, 0);
    vid_cycle(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1);
    chk("blank_release_t1", {BLANKn, R, G, B}, 0);
    vid_cycle(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1);
    chk("blank_release_t2", {BLANKn, R, G, B}, {1'b1, 24'hFFFFFF});

    // Video lookup in the same clock as a CPU write of that entry.
    vid_cycle(1'b1, 1'b1, 12'h000, 1'b1, 1'b1);
    @(negedge clk);
    ce_13m = 1'b1; ce_pixel = 1'b0; VA = 12'h000; Din = ~model_mem[12'h000];
    RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; DARCSn = 1'b0;
    @(negedge clk);
    ce_pixel = 1'b1; IM = 12'h000; HBLOn = 1'b1; VBLOn = 1'b1;
    @(posedge clk);
    #1;
    hist.push_back({1'b0, 12'h000});
    model_update();
    chk("collide_old", {BLANKn, R, G, B}, exp_vid);
    model_mem[12'h000] = Din;
    @(negedge clk);
    ce_pixel = 1'b0; DARCSn = 1'b1;
    repeat (3) @(posedge clk);
    vid_cycle(1'b1, 1'b1, 12'h000, 1'b1, 1'b1);
    chk("collide_new", {BLANKn, R, G, B}, {1'b1, colour(model_mem[12'h000])});

    // Strobe released during ACCESS: write lands, no acknowledge.
    @(negedge clk);
    ce_13m = 1'b1; ce_pixel = 1'b0; VA = vaddr[5]; Din = 16'h5A5A;
    RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; DARCSn = 1'b0;
    @(posedge clk);
    #1;
    chk("access_no_ack", {31'd0, DACKn}, 1);
    @(negedge clk);
    DARCSn = 1'b1;
    model_mem[vaddr[5]] = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("no_ack_pulse", {31'd0, DACKn}, 1);
    end
    vid_cycle(1'b1, 1'b1, vaddr[5], 1'b1, 1'b1);
    vid_cycle(1'b1, 1'b1, vaddr[5], 1'b1, 1'b1);

    // Reset during ACCESS discards the pending write.
    @(negedge clk);
    ce_13m = 1'b1; ce_pixel = 1'b0; VA = vaddr[3]; Din = ~model_mem[vaddr[3]];
    RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; DARCSn = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_access_dackn", {31'd0, DACKn}, 1);
    @(negedge clk);
    DARCSn = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    vid_reset_model();
    vid_cycle(1'b1, 1'b1, vaddr[3], 1'b1, 1'b1);
    vid_cycle(1'b1, 1'b1, vaddr[3], 1'b1, 1'b1);

    // Reset during ACK: DACKn rises at once, next strobe serviced normally.
    @(negedge clk);
    ce_13m = 1'b1; ce_pixel = 1'b0; VA = vaddr[4]; Din = 16'h2468;
    RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; DARCSn = 1'b0;
    for (int i = 0; i < 20 && DACKn; i++) @(negedge clk);
    chk("ack_reached", {31'd0, DACKn}, 0);
    model_mem[vaddr[4]] = 16'h2468;
    #2 resetn = 1'b0;
    #1;
    chk("rst_ack_dackn", {31'd0, DACKn}, 1);
    chk("rst_ack_dout", Dout, 0);
    chk("rst_ack_video", {BLANKn, R, G, B}, 0);
    @(negedge clk);
    DARCSn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    vid_reset_model();
    cpu_xfer(1'b1, vaddr[4], 16'h0, 1'b1, 1'b1, 2, 1'b0);

    // Randomized video traffic over the populated entries.
    for (int i = 0; i < 400; i++)
      vid_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                vaddr[$urandom_range(0, 15)],
                $urandom_range(0, 5) != 0, $urandom_range(0, 7) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
